// File: rtl/cpu_instr_sequencer.sv
// Instruction stimulus engine for the single-cycle CPU: replays a programmable
// table of instructions and checks each write-back value against its expectation.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | NOP driven, waiting for start
// RUN    | one table entry driven and checked per cycle
// PAUSE  | step mode, NOP driven, waiting for a step pulse
// STEP   | step mode, entry cur_idx driven and checked for one cycle
// DONE   | run finished, results held until start or abort
module cpu_instr_sequencer #(
  parameter int              XLEN  = 32,
  parameter int              DEPTH = 16,
  parameter int              IDX_W = $clog2(DEPTH),
  parameter int              ERR_W = 8,
  parameter logic [XLEN-1:0] NOP   = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             prog_we,
  input  logic [IDX_W-1:0] prog_addr,
  input  logic [XLEN-1:0]  prog_instr,
  input  logic [XLEN-1:0]  prog_expect,
  input  logic             prog_chk,
  input  logic [IDX_W:0]   prog_len,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic             abort,
  input  logic [XLEN-1:0]  Final_Result,
  output logic [XLEN-1:0]  Instr,
  output logic             instr_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [IDX_W-1:0] first_err_idx,
  output logic [IDX_W-1:0] cur_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_STEP,
    S_DONE
  } state_t;

  localparam logic [IDX_W:0] DEPTH_W = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] ONE_W   = (IDX_W+1)'(1);

  state_t state_q, state_d;

  logic [XLEN-1:0]  tbl_instr  [DEPTH];
  logic [XLEN-1:0]  tbl_expect [DEPTH];
  logic [DEPTH-1:0] tbl_chk;

  logic [IDX_W-1:0] cur_idx_q;
  logic [IDX_W:0]   len_q;
  logic [IDX_W:0]   len_new;
  logic [ERR_W-1:0] err_q;
  logic [IDX_W-1:0] first_q;

  logic idle_or_done;
  logic start_ok;
  logic prog_ok;
  logic drive;
  logic is_last;
  logic mismatch;
  logic err_sat;

  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign start_ok     = start && idle_or_done && !abort;
  assign prog_ok      = prog_we && idle_or_done && ({1'b0, prog_addr} < DEPTH_W);
  assign len_new      = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;
  assign drive        = (state_q == S_RUN) || (state_q == S_STEP);
  assign is_last      = (({1'b0, cur_idx_q} + ONE_W) == len_q);
  assign mismatch     = drive && tbl_chk[cur_idx_q] &&
                        (Final_Result != tbl_expect[cur_idx_q]);
  assign err_sat      = &err_q;

  // Table is plain storage with no reset so a program survives Reset_n.
  always_ff @(posedge clk) begin
    if (prog_ok) begin
      tbl_instr[prog_addr]  <= prog_instr;
      tbl_expect[prog_addr] <= prog_expect;
      tbl_chk[prog_addr]    <= prog_chk;
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (len_new == '0) begin
            state_d = S_DONE;
          end else if (step_mode) begin
            state_d = S_PAUSE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (is_last) begin
          state_d = S_DONE;
        end
      end
      S_PAUSE: begin
        if (step) begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        state_d = is_last ? S_DONE : S_PAUSE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
    end
  end

  // err_count is left untouched by abort so a stopped run can still be inspected.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cur_idx_q <= '0;
      len_q     <= '0;
      err_q     <= '0;
      first_q   <= '0;
    end else if (abort) begin
      cur_idx_q <= '0;
    end else if (start_ok) begin
      cur_idx_q <= '0;
      len_q     <= len_new;
      err_q     <= '0;
      first_q   <= '0;
    end else if (drive) begin
      if (mismatch) begin
        if (!err_sat) begin
          err_q <= err_q + 1'b1;
        end
        if (err_q == '0) begin
          first_q <= cur_idx_q;
        end
      end
      if (!is_last) begin
        cur_idx_q <= cur_idx_q + 1'b1;
      end
    end
  end

  assign Instr         = drive ? tbl_instr[cur_idx_q] : NOP;
  assign instr_valid   = drive;
  assign busy          = (state_q == S_RUN) || (state_q == S_PAUSE) || (state_q == S_STEP);
  assign done          = (state_q == S_DONE);
  assign pass          = (state_q == S_DONE) && (err_q == '0);
  assign err_count     = err_q;
  assign first_err_idx = first_q;
  assign cur_idx       = cur_idx_q;

endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// Bench for cpu_instr_sequencer: vector table, directed corner sequences and
// random runs checked against a list-level model of the program table.
`timescale 1ns/1ps
module tb_cpu_instr_sequencer;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 16;
  localparam int          IDX_W = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             Reset_n = 1'b0;
  logic             prog_we = 1'b0;
  logic [IDX_W-1:0] prog_addr = '0;
  logic [XLEN-1:0]  prog_instr = '0;
  logic [XLEN-1:0]  prog_expect = '0;
  logic             prog_chk = 1'b0;
  logic [IDX_W:0]   prog_len = '0;
  logic             start = 1'b0;
  logic             step_mode = 1'b0;
  logic             step = 1'b0;
  logic             abort = 1'b0;
  logic [XLEN-1:0]  Final_Result = '0;

  logic [XLEN-1:0]  Instr;
  logic             instr_valid, busy, done, pass;
  logic [7:0]       err_count;
  logic [IDX_W-1:0] first_err_idx, cur_idx;

  logic [XLEN-1:0]  s_instr;
  logic             s_valid, s_busy, s_done, s_pass;
  logic [1:0]       s_err;
  logic [IDX_W-1:0] s_first, s_cur;

  cpu_instr_sequencer u_dut (
    .clk(clk), .Reset_n(Reset_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_instr(prog_instr), .prog_expect(prog_expect), .prog_chk(prog_chk),
    .prog_len(prog_len), .start(start), .step_mode(step_mode), .step(step),
    .abort(abort), .Final_Result(Final_Result), .Instr(Instr),
    .instr_valid(instr_valid), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx), .cur_idx(cur_idx)
  );

  cpu_instr_sequencer #(.ERR_W(2)) u_sat (
    .clk(clk), .Reset_n(Reset_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_instr(prog_instr), .prog_expect(prog_expect), .prog_chk(prog_chk),
    .prog_len(prog_len), .start(start), .step_mode(step_mode), .step(step),
    .abort(abort), .Final_Result(Final_Result), .Instr(s_instr),
    .instr_valid(s_valid), .busy(s_busy), .done(s_done), .pass(s_pass),
    .err_count(s_err), .first_err_idx(s_first), .cur_idx(s_cur)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_instr [DEPTH];
  logic [31:0] m_exp   [DEPTH];
  bit          m_chk   [DEPTH];
  logic [31:0] fr      [DEPTH];

  typedef struct {
    int          plen;
    logic [15:0] mask;
    int          e_err;
    int          e_first;
    bit          e_pass;
    int          e_sat;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input int a, input logic [31:0] ins, input logic [31:0] ex, input bit c);
    prog_we     = 1'b1;
    prog_addr   = IDX_W'(a);
    prog_instr  = ins;
    prog_expect = ex;
    prog_chk    = c;
    tick();
    prog_we     = 1'b0;
    m_instr[a]  = ins;
    m_exp[a]    = ex;
    m_chk[a]    = c;
  endtask

  // Expected outcome is derived from the table model and the write-back list.
  task automatic body(input int plen, input bit smode, input int maxgap);
    int L, cnt, first, gap;
    bit seen;
    L = (plen > DEPTH) ? DEPTH : plen;
    cnt = 0; first = 0; seen = 0;
    for (int k = 0; k < L; k++) begin
      if (m_chk[k] && fr[k] != m_exp[k]) begin
        if (!seen) first = k;
        seen = 1;
        cnt++;
      end
    end
    for (int k = 0; k < L; k++) begin
      if (smode) begin
        gap = $urandom_range(maxgap, 0);
        for (int j = 0; j <= gap; j++) begin
          check("pause_instr", Instr, NOP);
          check("pause_valid", instr_valid, 0);
          check("pause_busy", busy, 1);
          check("pause_done", done, 0);
          if (j == gap) step = 1'b1;
          tick();
          step = 1'b0;
        end
      end
      check("instr", Instr, m_instr[k]);
      check("valid", instr_valid, 1);
      check("busy", busy, 1);
      check("early_done", done, 0);
      check("cur_idx", cur_idx, 32'(k));
      Final_Result = fr[k];
      tick();
    end
    check("done", done, 1);
    check("done_busy", busy, 0);
    check("done_valid", instr_valid, 0);
    check("done_instr", Instr, NOP);
    check("pass", pass, 32'(cnt == 0));
    check("err_count", err_count, 32'((cnt > 255) ? 255 : cnt));
    check("first_err", first_err_idx, 32'(first));
    check("sat_err", s_err, 32'((cnt > 3) ? 3 : cnt));
  endtask

  task automatic run(input int plen, input bit smode, input int maxgap);
    prog_len  = (IDX_W+1)'(plen);
    step_mode = smode;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    body(plen, smode, maxgap);
  endtask

  task automatic fr_match();
    for (int k = 0; k < DEPTH; k++) fr[k] = m_exp[k];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{3,  16'h0000, 0,  0,  1'b1, 0};
    vecs[1] = '{3,  16'h0002, 1,  1,  1'b0, 1};
    vecs[2] = '{3,  16'h0004, 0,  0,  1'b1, 0};
    vecs[3] = '{0,  16'hFFFF, 0,  0,  1'b1, 0};
    vecs[4] = '{5,  16'h001A, 3,  1,  1'b0, 3};
    vecs[5] = '{20, 16'h8000, 1,  15, 1'b0, 1};
    vecs[6] = '{16, 16'hFFFF, 15, 0,  1'b0, 3};
    vecs[7] = '{2,  16'h0003, 2,  0,  1'b0, 2};

    #23;
    check("rst_instr", Instr, NOP);
    check("rst_valid", instr_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_first", first_err_idx, 0);
    check("rst_cur", cur_idx, 0);
    Reset_n = 1'b1;

    prog(0, 32'h00C00193, 32'd12, 1'b1);
    prog(1, 32'h00700393, 32'd7,  1'b1);
    prog(2, 32'h0471AA23, 32'd0,  1'b0);
    for (int k = 3; k < DEPTH; k++) prog(k, 32'h00000093 | (32'(k) << 20), 32'(k * 5), 1'b1);

    for (int v = 0; v < 8; v++) begin
      logic [15:0] msk;
      msk = vecs[v].mask;
      for (int k = 0; k < DEPTH; k++) fr[k] = msk[k] ? (m_exp[k] ^ 32'h1) : m_exp[k];
      run(vecs[v].plen, 1'b0, 0);
      check("vec_err", err_count, 32'(vecs[v].e_err));
      check("vec_first", first_err_idx, 32'(vecs[v].e_first));
      check("vec_pass", pass, 32'(vecs[v].e_pass));
      check("vec_sat", s_err, 32'(vecs[v].e_sat));
    end

    // write and start in the same cycle: run must see expect=8 for entry 1
    fr_match();
    prog_we = 1'b1; prog_addr = 4'd1; prog_instr = 32'h00700393;
    prog_expect = 32'd8; prog_chk = 1'b1;
    prog_len = 5'd3; step_mode = 1'b0; start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    m_exp[1] = 32'd8;
    body(3, 1'b0, 0);
    check("t2_err", err_count, 1);
    check("t2_first", first_err_idx, 1);
    check("t2_pass", pass, 0);

    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_done", done, 0);
    check("abort_pass", pass, 0);
    check("abort_busy", busy, 0);
    check("abort_err_held", err_count, 1);
    prog(1, 32'h00700393, 32'd7, 1'b1);

    prog(2, 32'h0471AA23, 32'd0, 1'b1);
    for (int k = 0; k < DEPTH; k++) fr[k] = ~m_exp[k];
    run(16, 1'b0, 0);
    check("t4_sat", s_err, 3);
    check("t4_err", err_count, 16);
    check("t4_first", first_err_idx, 0);
    prog(2, 32'h0471AA23, 32'd0, 1'b0);

    // step mode with a write attempt while paused (must be dropped)
    fr_match();
    prog_len = 5'd2; step_mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_nop", Instr, NOP);
    check("t3_busy", busy, 1);
    prog_we = 1'b1; prog_addr = 4'd0; prog_instr = 32'hDEADBEEF;
    prog_expect = 32'h1; prog_chk = 1'b1;
    tick();
    prog_we = 1'b0;
    body(2, 1'b1, 2);
    step = 1'b1;
    tick();
    tick();
    step = 1'b0;
    check("t3_post_done", done, 1);
    check("t3_post_instr", Instr, NOP);
    check("t3_post_valid", instr_valid, 0);
    check("t3_post_cur", cur_idx, 1);

    // start while busy is ignored, then abort mid-run
    fr_match();
    prog_len = 5'd10; step_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      Final_Result = fr[k];
      tick();
    end
    check("busy_cur", cur_idx, 3);
    start = 1'b1;
    Final_Result = fr[3];
    tick();
    start = 1'b0;
    check("busy_start_cur", cur_idx, 4);
    check("busy_start_instr", Instr, m_instr[4]);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("mid_abort_busy", busy, 0);
    check("mid_abort_done", done, 0);
    check("mid_abort_valid", instr_valid, 0);
    check("mid_abort_instr", Instr, NOP);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("idle_step_busy", busy, 0);
    check("idle_step_valid", instr_valid, 0);

    // async reset mid-run, table must survive
    prog_len = 5'd16; step_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      Final_Result = fr[k];
      tick();
    end
    check("pre_rst_cur", cur_idx, 5);
    #2;
    Reset_n = 1'b0;
    #1;
    check("mid_rst_instr", Instr, NOP);
    check("mid_rst_valid", instr_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cur", cur_idx, 0);
    check("mid_rst_err", err_count, 0);
    @(negedge clk);
    Reset_n = 1'b1;
    fr[7] = ~m_exp[7];
    run(16, 1'b0, 0);
    check("rerun_first", first_err_idx, 7);

    for (int it = 0; it < 40; it++) begin
      int nw;
      nw = $urandom_range(3, 0);
      for (int w = 0; w < nw; w++)
        prog($urandom_range(15, 0), $urandom, $urandom, ($urandom_range(3, 0) != 0));
      for (int k = 0; k < DEPTH; k++)
        fr[k] = ($urandom_range(2, 0) == 0) ? (m_exp[k] ^ (32'h1 << $urandom_range(31, 0))) : m_exp[k];
      run($urandom_range(20, 0), 1'($urandom_range(1, 0)), 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
